// File: rtl/cgra_edge_port_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : cgra_edge_port_adapter
//  Description : Host-side endpoint for one CGRA mesh edge port.
//                TX splits a host word into a low/high routed flit pair.
//                RX reassembles ejected flit pairs into host words and
//                counts out-of-order (sequencing) errors.
//  Revision    : 1.0  initial release
// ============================================================================
module cgra_edge_port_adapter #(
    parameter int DATA_WIDTH    = 32,
    parameter int COORD_WIDTH   = 4,
    parameter int PAYLOAD_WIDTH = 16,
    parameter int ERR_WIDTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    // host TX side
    input  logic [2*PAYLOAD_WIDTH-1:0] host_tx_data,
    input  logic [COORD_WIDTH-1:0]     host_tx_dst_x,
    input  logic [COORD_WIDTH-1:0]     host_tx_dst_y,
    input  logic                       host_tx_valid,
    output logic                       host_tx_ready,
    // mesh injection side
    output logic [DATA_WIDTH-1:0]      noc_data_out,
    output logic                       noc_valid_out,
    input  logic                       noc_ready_in,
    // mesh ejection side
    input  logic [DATA_WIDTH-1:0]      noc_data_in,
    input  logic                       noc_valid_in,
    output logic                       noc_ready_out,
    // host RX side
    output logic [2*PAYLOAD_WIDTH-1:0] host_rx_data,
    output logic                       host_rx_valid,
    input  logic                       host_rx_ready,
    // status
    output logic [ERR_WIDTH-1:0]       rx_err_count
);

    localparam int WORD_WIDTH = 2 * PAYLOAD_WIDTH;
    // Flit bit that marks the high half of a word.
    localparam int HALF_BIT   = PAYLOAD_WIDTH;

    typedef enum logic [1:0] {
        TX_IDLE    = 2'd0,
        TX_SEND_LO = 2'd1,
        TX_SEND_HI = 2'd2
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_WAIT_LO = 2'd0,
        RX_WAIT_HI = 2'd1,
        RX_FULL    = 2'd2
    } rx_state_t;

    // ------------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------------
    tx_state_t             r_tx_state;
    logic [DATA_WIDTH-1:0] r_tx_flit;
    logic                  r_tx_valid;
    // High flit is built at accept time so host_tx_data may change freely
    // while the low flit is still waiting on the mesh.
    logic [DATA_WIDTH-1:0] r_tx_hi_flit;

    logic [DATA_WIDTH-1:0] w_lo_flit;
    logic [DATA_WIDTH-1:0] w_hi_flit;
    logic                  w_tx_accept;
    logic                  w_tx_xfer;

    // Build both flits of the word currently offered by the host.
    always_comb begin
        w_lo_flit                                              = '0;
        w_lo_flit[DATA_WIDTH-1 -: COORD_WIDTH]                 = host_tx_dst_x;
        w_lo_flit[DATA_WIDTH-COORD_WIDTH-1 -: COORD_WIDTH]     = host_tx_dst_y;
        w_lo_flit[HALF_BIT]                                    = 1'b0;
        w_lo_flit[PAYLOAD_WIDTH-1:0]                           = host_tx_data[PAYLOAD_WIDTH-1:0];
        w_hi_flit                                              = w_lo_flit;
        w_hi_flit[HALF_BIT]                                    = 1'b1;
        w_hi_flit[PAYLOAD_WIDTH-1:0]                           = host_tx_data[WORD_WIDTH-1:PAYLOAD_WIDTH];
    end

    // A new word may enter when idle, or in the same cycle the high flit
    // leaves, which gives the sustained two-cycles-per-word rate.
    assign host_tx_ready = (r_tx_state == TX_IDLE) |
                           ((r_tx_state == TX_SEND_HI) & noc_ready_in);
    assign w_tx_accept   = host_tx_valid & host_tx_ready;
    assign w_tx_xfer     = r_tx_valid & noc_ready_in;

    // TX sequencer: holds each flit stable until the mesh takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state   <= TX_IDLE;
            r_tx_flit    <= '0;
            r_tx_hi_flit <= '0;
            r_tx_valid   <= 1'b0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_tx_accept) begin
                        r_tx_flit    <= w_lo_flit;
                        r_tx_hi_flit <= w_hi_flit;
                        r_tx_valid   <= 1'b1;
                        r_tx_state   <= TX_SEND_LO;
                    end
                end
                TX_SEND_LO: begin
                    if (w_tx_xfer) begin
                        r_tx_flit  <= r_tx_hi_flit;
                        r_tx_state <= TX_SEND_HI;
                    end
                end
                TX_SEND_HI: begin
                    if (w_tx_xfer) begin
                        if (w_tx_accept) begin
                            r_tx_flit    <= w_lo_flit;
                            r_tx_hi_flit <= w_hi_flit;
                            r_tx_state   <= TX_SEND_LO;
                        end else begin
                            r_tx_flit  <= '0;
                            r_tx_valid <= 1'b0;
                            r_tx_state <= TX_IDLE;
                        end
                    end
                end
                default: begin
                    r_tx_flit  <= '0;
                    r_tx_valid <= 1'b0;
                    r_tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    assign noc_data_out  = r_tx_flit;
    assign noc_valid_out = r_tx_valid;

    // ------------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------------
    rx_state_t                r_rx_state;
    logic [PAYLOAD_WIDTH-1:0] r_rx_lo_buf;
    logic [WORD_WIDTH-1:0]    r_rx_word;
    logic                     r_rx_valid;
    logic [ERR_WIDTH-1:0]     r_err_count;

    logic                     w_rx_xfer;
    logic                     w_rx_is_hi;
    logic [PAYLOAD_WIDTH-1:0] w_rx_payload;
    logic                     w_rx_err;
    // Routing header of ejected flits carries no information for the host.
    logic                     w_unused_rx_hdr;

    assign noc_ready_out   = (r_rx_state != RX_FULL);
    assign w_rx_xfer       = noc_valid_in & noc_ready_out;
    assign w_rx_is_hi      = noc_data_in[HALF_BIT];
    assign w_rx_payload    = noc_data_in[PAYLOAD_WIDTH-1:0];
    assign w_unused_rx_hdr = ^noc_data_in[DATA_WIDTH-1:HALF_BIT+1];

    // A high flit with no preceding low, or a second low before the high,
    // is a sequencing error.
    assign w_rx_err = w_rx_xfer &
                      (((r_rx_state == RX_WAIT_LO) &  w_rx_is_hi) |
                       ((r_rx_state == RX_WAIT_HI) & ~w_rx_is_hi));

    // RX reassembly: low half is buffered, the word is published only once
    // the high half arrives, and held until the host takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state  <= RX_WAIT_LO;
            r_rx_lo_buf <= '0;
            r_rx_word   <= '0;
            r_rx_valid  <= 1'b0;
        end else begin
            case (r_rx_state)
                RX_WAIT_LO: begin
                    if (w_rx_xfer && !w_rx_is_hi) begin
                        r_rx_lo_buf <= w_rx_payload;
                        r_rx_state  <= RX_WAIT_HI;
                    end
                end
                RX_WAIT_HI: begin
                    if (w_rx_xfer) begin
                        if (w_rx_is_hi) begin
                            r_rx_word  <= {w_rx_payload, r_rx_lo_buf};
                            r_rx_valid <= 1'b1;
                            r_rx_state <= RX_FULL;
                        end else begin
                            // Newest low half wins; the older one is lost.
                            r_rx_lo_buf <= w_rx_payload;
                        end
                    end
                end
                RX_FULL: begin
                    if (host_rx_ready) begin
                        r_rx_valid <= 1'b0;
                        r_rx_state <= RX_WAIT_LO;
                    end
                end
                default: begin
                    r_rx_valid <= 1'b0;
                    r_rx_state <= RX_WAIT_LO;
                end
            endcase
        end
    end

    // Saturating error counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (w_rx_err && (r_err_count != {ERR_WIDTH{1'b1}})) begin
            r_err_count <= r_err_count + ERR_WIDTH'(1);
        end
    end

    assign host_rx_data  = r_rx_word;
    assign host_rx_valid = r_rx_valid;
    assign rx_err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_cgra_edge_port_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cgra_edge_port_adapter
//  Description : Directed, table-driven bench for cgra_edge_port_adapter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cgra_edge_port_adapter;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int PW = 16;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   host_tx_data;
    logic [3:0]    host_tx_dst_x;
    logic [3:0]    host_tx_dst_y;
    logic          host_tx_valid;
    logic          host_tx_ready;
    logic [31:0]   noc_data_out;
    logic          noc_valid_out;
    logic          noc_ready_in;
    logic [31:0]   noc_data_in;
    logic          noc_valid_in;
    logic          noc_ready_out;
    logic [31:0]   host_rx_data;
    logic          host_rx_valid;
    logic          host_rx_ready;
    logic [7:0]    rx_err_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  x;
        logic [3:0]  y;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
    } tx_vec_t;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] exp_word;
    } rx_vec_t;

    tx_vec_t     tx_tab [4];
    rx_vec_t     rx_tab [3];
    logic [31:0] t3_w   [4];

    cgra_edge_port_adapter #(
        .DATA_WIDTH    (DW),
        .COORD_WIDTH   (CW),
        .PAYLOAD_WIDTH (PW),
        .ERR_WIDTH     (EW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .host_tx_data  (host_tx_data),
        .host_tx_dst_x (host_tx_dst_x),
        .host_tx_dst_y (host_tx_dst_y),
        .host_tx_valid (host_tx_valid),
        .host_tx_ready (host_tx_ready),
        .noc_data_out  (noc_data_out),
        .noc_valid_out (noc_valid_out),
        .noc_ready_in  (noc_ready_in),
        .noc_data_in   (noc_data_in),
        .noc_valid_in  (noc_valid_in),
        .noc_ready_out (noc_ready_out),
        .host_rx_data  (host_rx_data),
        .host_rx_valid (host_rx_valid),
        .host_rx_ready (host_rx_ready),
        .rx_err_count  (rx_err_count)
    );

    always #5 clk = ~clk;

    // Hard stop in case anything stalls the sequence.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h required %h", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One word through TX with the mesh always ready; starts idle, 1ns after an edge.
    task automatic tx_word(input tx_vec_t v, input int idx);
        host_tx_data  = v.data;
        host_tx_dst_x = v.x;
        host_tx_dst_y = v.y;
        host_tx_valid = 1'b1;
        noc_ready_in  = 1'b1;
        #1;
        chk("tx_ready_idle", idx, 32'(host_tx_ready), 32'd1);
        tick();
        host_tx_valid = 1'b0;
        chk("tx_lo_valid", idx, 32'(noc_valid_out), 32'd1);
        chk("tx_lo_flit",  idx, noc_data_out, v.exp_lo);
        tick();
        chk("tx_hi_valid", idx, 32'(noc_valid_out), 32'd1);
        chk("tx_hi_flit",  idx, noc_data_out, v.exp_hi);
        tick();
        chk("tx_done_valid", idx, 32'(noc_valid_out), 32'd0);
    endtask

    // One flit pair through RX; starts in WAIT_LO, 1ns after an edge.
    task automatic rx_word(input rx_vec_t v, input int idx);
        host_rx_ready = 1'b0;
        noc_valid_in  = 1'b1;
        noc_data_in   = v.lo;
        #1;
        chk("rx_ready_lo", idx, 32'(noc_ready_out), 32'd1);
        tick();
        chk("rx_valid_early", idx, 32'(host_rx_valid), 32'd0);
        noc_data_in = v.hi;
        tick();
        noc_valid_in = 1'b0;
        chk("rx_valid", idx, 32'(host_rx_valid), 32'd1);
        chk("rx_word",  idx, host_rx_data, v.exp_word);
        chk("rx_ready_full", idx, 32'(noc_ready_out), 32'd0);
        host_rx_ready = 1'b1;
        tick();
        host_rx_ready = 1'b0;
        chk("rx_taken", idx, 32'(host_rx_valid), 32'd0);
    endtask

    initial begin
        tx_tab[0] = '{32'hDEADBEEF, 4'd2,  4'd1,  32'h2100BEEF, 32'h2101DEAD};
        tx_tab[1] = '{32'h00000000, 4'd0,  4'd0,  32'h00000000, 32'h00010000};
        tx_tab[2] = '{32'hFFFFFFFF, 4'd15, 4'd15, 32'hFF00FFFF, 32'hFF01FFFF};
        tx_tab[3] = '{32'h12345678, 4'd3,  4'd10, 32'h3A005678, 32'h3A011234};

        rx_tab[0] = '{32'h00001234, 32'h0001ABCD, 32'hABCD1234};
        rx_tab[1] = '{32'h3A005678, 32'h3A011234, 32'h12345678};
        rx_tab[2] = '{32'hFFFEFFFF, 32'hFFFF0000, 32'h0000FFFF};

        t3_w[0] = 32'h11112222;
        t3_w[1] = 32'h33334444;
        t3_w[2] = 32'h55556666;
        t3_w[3] = 32'h77778888;

        rst_n         = 1'b0;
        host_tx_data  = '0;
        host_tx_dst_x = '0;
        host_tx_dst_y = '0;
        host_tx_valid = 1'b0;
        noc_ready_in  = 1'b0;
        noc_data_in   = '0;
        noc_valid_in  = 1'b0;
        host_rx_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_valid_out", 0, 32'(noc_valid_out), 32'd0);
        chk("rst_data_out",  0, noc_data_out, 32'd0);
        chk("rst_rx_valid",  0, 32'(host_rx_valid), 32'd0);
        chk("rst_rx_data",   0, host_rx_data, 32'd0);
        chk("rst_err",       0, 32'(rx_err_count), 32'd0);
        chk("rst_tx_ready",  0, 32'(host_tx_ready), 32'd1);
        chk("rst_rx_ready",  0, 32'(noc_ready_out), 32'd1);
        rst_n = 1'b1;
        tick();

        // T1 and other single words through TX
        for (int i = 0; i < 4; i++) tx_word(tx_tab[i], i);

        // RX reassembly vectors
        for (int i = 0; i < 3; i++) rx_word(rx_tab[i], i);
        chk("rx_err_clean", 0, 32'(rx_err_count), 32'd0);

        // T2: stall the low flit for 5 cycles
        host_tx_data  = 32'hCAFEF00D;
        host_tx_dst_x = 4'd5;
        host_tx_dst_y = 4'd6;
        host_tx_valid = 1'b1;
        noc_ready_in  = 1'b0;
        tick();
        host_tx_data = 32'h0BADC0DE;
        for (int i = 0; i < 5; i++) begin
            chk("t2_stall_valid", i, 32'(noc_valid_out), 32'd1);
            chk("t2_stall_flit",  i, noc_data_out, 32'h5600F00D);
            chk("t2_stall_ready", i, 32'(host_tx_ready), 32'd0);
            tick();
        end
        noc_ready_in = 1'b1;
        #1;
        chk("t2_lo_ready", 0, 32'(host_tx_ready), 32'd0);
        tick();
        chk("t2_hi_flit",  0, noc_data_out, 32'h5601CAFE);
        chk("t2_hi_ready", 0, 32'(host_tx_ready), 32'd1);
        tick();
        host_tx_valid = 1'b0;
        chk("t2_next_lo", 0, noc_data_out, 32'h5600C0DE);
        tick();
        chk("t2_next_hi", 0, noc_data_out, 32'h56010BAD);
        tick();
        chk("t2_idle", 0, 32'(noc_valid_out), 32'd0);

        // T3: four back-to-back words, eight consecutive flits
        host_tx_dst_x = 4'd1;
        host_tx_dst_y = 4'd2;
        host_tx_data  = t3_w[0];
        host_tx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] w;
            logic [15:0] pay;
            w   = t3_w[i/2];
            pay = (i % 2 == 1) ? w[31:16] : w[15:0];
            tick();
            chk("t3_valid", i, 32'(noc_valid_out), 32'd1);
            chk("t3_flit",  i, noc_data_out, {4'h1, 4'h2, 7'h0, 1'((i % 2) == 1), pay});
            if (i % 2 == 0) begin
                if (i < 6) host_tx_data = t3_w[i/2 + 1];
                else       host_tx_valid = 1'b0;
            end
        end
        tick();
        chk("t3_idle", 0, 32'(noc_valid_out), 32'd0);

        // T4: host holds off; a waiting flit must not be taken while full
        noc_valid_in = 1'b1;
        noc_data_in  = 32'h00001234;
        tick();
        chk("t4_early", 0, 32'(host_rx_valid), 32'd0);
        noc_data_in = 32'h0001ABCD;
        tick();
        chk("t4_word", 0, host_rx_data, 32'hABCD1234);
        noc_data_in = 32'h00005555;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_hold_ready", i, 32'(noc_ready_out), 32'd0);
            chk("t4_hold_valid", i, 32'(host_rx_valid), 32'd1);
            chk("t4_hold_word",  i, host_rx_data, 32'hABCD1234);
        end
        host_rx_ready = 1'b1;
        tick();
        host_rx_ready = 1'b0;
        chk("t4_taken", 0, 32'(host_rx_valid), 32'd0);
        chk("t4_ready", 0, 32'(noc_ready_out), 32'd1);
        tick();
        noc_data_in = 32'h00016666;
        tick();
        noc_valid_in = 1'b0;
        chk("t4_next_word", 0, host_rx_data, 32'h66665555);
        chk("t4_err", 0, 32'(rx_err_count), 32'd0);
        host_rx_ready = 1'b1;
        tick();
        host_rx_ready = 1'b0;

        // T5: sequencing errors and saturation
        noc_valid_in = 1'b1;
        noc_data_in  = 32'h00010001;
        tick();
        chk("t5_err_hi_first", 0, 32'(rx_err_count), 32'd1);
        chk("t5_no_word", 0, 32'(host_rx_valid), 32'd0);
        noc_data_in = 32'h00001111;
        tick();
        chk("t5_err_lo1", 0, 32'(rx_err_count), 32'd1);
        noc_data_in = 32'h00002222;
        tick();
        chk("t5_err_lo2", 0, 32'(rx_err_count), 32'd2);
        noc_data_in = 32'h00013333;
        tick();
        noc_valid_in = 1'b0;
        chk("t5_word", 0, host_rx_data, 32'h33332222);
        chk("t5_err_final", 0, 32'(rx_err_count), 32'd2);
        host_rx_ready = 1'b1;
        tick();
        host_rx_ready = 1'b0;
        noc_valid_in = 1'b1;
        noc_data_in  = 32'h00010000;
        repeat (252) tick();
        chk("t5_sat_254", 0, 32'(rx_err_count), 32'd254);
        tick();
        chk("t5_sat_255", 0, 32'(rx_err_count), 32'd255);
        repeat (45) tick();
        chk("t5_sat_hold", 0, 32'(rx_err_count), 32'd255);
        noc_valid_in = 1'b0;

        // T6: reset with TX in SEND_HI and RX in WAIT_HI
        host_tx_data  = 32'h0F0F0F0F;
        host_tx_dst_x = 4'd1;
        host_tx_dst_y = 4'd1;
        host_tx_valid = 1'b1;
        noc_ready_in  = 1'b1;
        noc_valid_in  = 1'b1;
        noc_data_in   = 32'h00007777;
        tick();
        host_tx_valid = 1'b0;
        noc_valid_in  = 1'b0;
        tick();
        noc_ready_in = 1'b0;
        chk("t6_pre_hi", 0, noc_data_out, 32'h11010F0F);
        rst_n = 1'b0;
        #1;
        chk("t6_valid_out", 0, 32'(noc_valid_out), 32'd0);
        chk("t6_data_out",  0, noc_data_out, 32'd0);
        chk("t6_rx_valid",  0, 32'(host_rx_valid), 32'd0);
        chk("t6_rx_data",   0, host_rx_data, 32'd0);
        chk("t6_err",       0, 32'(rx_err_count), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        tx_word('{32'hA5A55A5A, 4'd4, 4'd7, 32'h47005A5A, 32'h4701A5A5}, 10);
        rx_word('{32'h00008888, 32'h00019999, 32'h99998888}, 10);
        chk("t6_err_after", 0, 32'(rx_err_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
